lbdr_dr_router: RTL

// Next-generation LBDR routing unit for one router input port in a 2-D mesh. Parametrised coordinate width,

---
 rtl/lbdr_pkg.sv | 45 ++++
 rtl/lbdr_route_logic.sv | 92 +++++++++
 rtl/lbdr_dr_router.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lbdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lbdr_pkg
// Purpose  : Shared definitions for the LBDR routing unit. It holds the flit
//            type codes, the port index enum, the FSM state type, the reset
//            values of the configuration registers, and a one-hot helper.
// Revision : 1.0 - initial release
// ============================================================================
package lbdr_pkg;

    // Flit type codes at the head of the input FIFO
    localparam logic [2:0] C_FLIT_HEADER = 3'b001;
    localparam logic [2:0] C_FLIT_BODY   = 3'b010;
    localparam logic [2:0] C_FLIT_TAIL   = 3'b100;

    // Output port indices; the bit positions in req/grant/out_sel follow these
    typedef enum logic [2:0] {
        P_N = 3'd0,
        P_E = 3'd1,
        P_W = 3'd2,
        P_S = 3'd3,
        P_L = 3'd4
    } port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Configuration register reset values
    localparam logic [7:0] C_CFG_RXY_DEF      = 8'h3C;
    localparam logic [3:0] C_CFG_CX_DEF       = 4'hF;
    localparam logic [3:0] C_CFG_DR_EN_DEF    = 4'h0;
    localparam logic [7:0] C_CFG_DR_DEF       = 8'h00;
    localparam int         C_CFG_CUR_ADDR_DEF = 5;

    // One-hot 5-bit port vector for a port index
    function automatic logic [4:0] port_onehot(input logic [2:0] idx);
        return 5'(5'b00001 << idx);
    endfunction

endpackage : lbdr_pkg
`default_nettype wire

// File: rtl/lbdr_route_logic.sv
`default_nettype none
// ============================================================================
// Module   : lbdr_route_logic
// Purpose  : Combinational LBDR route computation. It returns the minimal
//            route, or a single deroute port when every minimal port is
//            blocked.
// Ports    : i_rxy        routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//            i_cx         connectivity {Cs,Cw,Ce,Cn}
//            i_dr_en      deroute enable {S,W,E,N}
//            i_dr         2-bit deroute port index per direction {S,W,E,N}
//            i_cur_addr   this router's address {y,x}
//            i_dst_addr   packet destination {y,x}
//            o_route      requested ports {L,S,W,E,N}
//            o_unroutable no legal port exists
// Revision : 1.0 - initial release
// ============================================================================
module lbdr_route_logic
    import lbdr_pkg::*;
#(
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int ADDR_W = X_W + Y_W
) (
    input  logic [7:0]        i_rxy,
    input  logic [3:0]        i_cx,
    input  logic [3:0]        i_dr_en,
    input  logic [7:0]        i_dr,
    input  logic [ADDR_W-1:0] i_cur_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    output logic [4:0]        o_route,
    output logic              o_unroutable
);

    logic [X_W-1:0] w_x_cur, w_x_dst;
    logic [Y_W-1:0] w_y_cur, w_y_dst;
    logic           w_n1, w_e1, w_w1, w_s1;
    logic           w_n, w_e, w_w, w_s, w_l;
    logic [3:0]     w_min;
    logic [1:0]     w_prim;
    logic [1:0]     w_dr_idx;
    logic           w_dr_ok;

    assign w_x_cur = i_cur_addr[X_W-1:0];
    assign w_x_dst = i_dst_addr[X_W-1:0];
    assign w_y_cur = i_cur_addr[ADDR_W-1:X_W];
    assign w_y_dst = i_dst_addr[ADDR_W-1:X_W];

    // North is towards decreasing y, east towards increasing x
    assign w_n1 = (w_y_dst < w_y_cur);
    assign w_s1 = (w_y_cur < w_y_dst);
    assign w_e1 = (w_x_cur < w_x_dst);
    assign w_w1 = (w_x_dst < w_x_cur);

    assign w_n = ((w_n1 & ~w_e1 & ~w_w1) | (w_n1 & w_e1 & i_rxy[0]) | (w_n1 & w_w1 & i_rxy[1])) & i_cx[0];
    assign w_e = ((w_e1 & ~w_n1 & ~w_s1) | (w_e1 & w_n1 & i_rxy[2]) | (w_e1 & w_s1 & i_rxy[3])) & i_cx[1];
    assign w_w = ((w_w1 & ~w_n1 & ~w_s1) | (w_w1 & w_n1 & i_rxy[4]) | (w_w1 & w_s1 & i_rxy[5])) & i_cx[2];
    assign w_s = ((w_s1 & ~w_e1 & ~w_w1) | (w_s1 & w_e1 & i_rxy[6]) | (w_s1 & w_w1 & i_rxy[7])) & i_cx[3];
    assign w_l = ~(w_n1 | w_e1 | w_w1 | w_s1);

    assign w_min = {w_s, w_w, w_e, w_n};

    // The primary direction is the first productive direction in N,E,W,S order.
    // Its index matches both the dr_en bit and the 2-bit slot in i_dr.
    always_comb begin
        w_prim = 2'd3;
        if (w_n1) begin
            w_prim = 2'd0;
        end else if (w_e1) begin
            w_prim = 2'd1;
        end else if (w_w1) begin
            w_prim = 2'd2;
        end
    end

    assign w_dr_idx = i_dr[{w_prim, 1'b0} +: 2];
    assign w_dr_ok  = i_dr_en[w_prim] & i_cx[w_dr_idx];

    always_comb begin
        o_route = 5'b00000;
        if (w_l) begin
            o_route = port_onehot(P_L);
        end else if (|w_min) begin
            o_route = {1'b0, w_min};
        end else if (w_dr_ok) begin
            o_route = port_onehot({1'b0, w_dr_idx});
        end
    end

    assign o_unroutable = ~(|o_route);

endmodule : lbdr_route_logic
`default_nettype wire

// File: rtl/lbdr_dr_router.sv
`default_nettype none
// ============================================================================
// Module   : lbdr_dr_router
// Purpose  : LBDR routing unit with deroutes for one mesh input port. It
//            routes each HEADER once, holds the request until the switch
//            allocator grants it, and keeps the granted port until the TAIL
//            flit is popped.
// Ports    : clk, rst (async active-low)
//            cfg_we/cfg_rxy/cfg_cx/cfg_dr_en/cfg_dr/cfg_cur_addr  config write
//            empty/flit_id/dst_addr/flit_pop   input FIFO head
//            grant                             allocator grant {L,S,W,E,N}
//            req                               allocator request (multi-hot)
//            out_sel                           one-hot held output port
//            route_err                         1-cycle unroutable pulse
// Revision : 1.0 - initial release
// ============================================================================
module lbdr_dr_router
    import lbdr_pkg::*;
#(
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int ADDR_W = X_W + Y_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_rxy,
    input  logic [3:0]        cfg_cx,
    input  logic [3:0]        cfg_dr_en,
    input  logic [7:0]        cfg_dr,
    input  logic [ADDR_W-1:0] cfg_cur_addr,
    input  logic              empty,
    input  logic [2:0]        flit_id,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              flit_pop,
    input  logic [4:0]        grant,
    output logic [4:0]        req,
    output logic [4:0]        out_sel,
    output logic              route_err
);

    state_t            r_state, w_state_nxt;
    logic [4:0]        r_req, w_req_nxt;
    logic [4:0]        r_out_sel, w_out_sel_nxt;
    logic              r_route_err, w_route_err_nxt;
    logic              w_cfg_load;

    logic [7:0]        r_cfg_rxy;
    logic [3:0]        r_cfg_cx;
    logic [3:0]        r_cfg_dr_en;
    logic [7:0]        r_cfg_dr;
    logic [ADDR_W-1:0] r_cfg_cur_addr;

    logic [4:0]        w_route;
    logic              w_unroutable;
    logic              w_hdr;
    logic              w_tail_pop;
    logic [4:0]        w_gvalid;
    logic [4:0]        w_gpick;

    lbdr_route_logic #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) u_route (
        .i_rxy        (r_cfg_rxy),
        .i_cx         (r_cfg_cx),
        .i_dr_en      (r_cfg_dr_en),
        .i_dr         (r_cfg_dr),
        .i_cur_addr   (r_cfg_cur_addr),
        .i_dst_addr   (dst_addr),
        .o_route      (w_route),
        .o_unroutable (w_unroutable)
    );

    assign w_hdr      = ~empty & (flit_id == C_FLIT_HEADER);
    // A pop while the FIFO reports empty is illegal and ignored
    assign w_tail_pop = flit_pop & ~empty & (flit_id == C_FLIT_TAIL);

    // Only grants for requested ports count; the lowest index wins (x & -x)
    assign w_gvalid = grant & r_req;
    assign w_gpick  = w_gvalid & (~w_gvalid + 5'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_req       <= 5'b00000;
            r_out_sel   <= 5'b00000;
            r_route_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_out_sel   <= w_out_sel_nxt;
            r_route_err <= w_route_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_out_sel_nxt   = r_out_sel;
        w_route_err_nxt = 1'b0;
        w_cfg_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_nxt     = 5'b00000;
                w_out_sel_nxt = 5'b00000;
                w_cfg_load    = cfg_we;
                if (w_hdr) begin
                    // The route uses the registered config, so a same-cycle write does not affect it
                    if (w_unroutable) begin
                        w_route_err_nxt = 1'b1;
                        w_state_nxt     = ST_DROP;
                    end else begin
                        w_req_nxt   = w_route;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (|w_gvalid) begin
                    w_out_sel_nxt = w_gpick;
                    w_req_nxt     = 5'b00000;
                    w_state_nxt   = ST_XFER;
                end
            end
            ST_XFER: begin
                w_req_nxt = 5'b00000;
                if (w_tail_pop) begin
                    w_out_sel_nxt = 5'b00000;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_DROP: begin
                w_req_nxt     = 5'b00000;
                w_out_sel_nxt = 5'b00000;
                if (w_tail_pop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_req_nxt     = 5'b00000;
                w_out_sel_nxt = 5'b00000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_rxy      <= C_CFG_RXY_DEF;
            r_cfg_cx       <= C_CFG_CX_DEF;
            r_cfg_dr_en    <= C_CFG_DR_EN_DEF;
            r_cfg_dr       <= C_CFG_DR_DEF;
            r_cfg_cur_addr <= ADDR_W'(C_CFG_CUR_ADDR_DEF);
        end else if (w_cfg_load) begin
            r_cfg_rxy      <= cfg_rxy;
            r_cfg_cx       <= cfg_cx;
            r_cfg_dr_en    <= cfg_dr_en;
            r_cfg_dr       <= cfg_dr;
            r_cfg_cur_addr <= cfg_cur_addr;
        end
    end

    assign req       = r_req;
    assign out_sel   = r_out_sel;
    assign route_err = r_route_err;

endmodule : lbdr_dr_router
`default_nettype wire
